// File: rtl/shift_sub_divider.sv
// Sequential restoring shift-and-subtract divider: one quotient bit per clock.
// Optional macro DIV_BY_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
module shift_sub_divider #(
   parameter int D_WIDTH     = 8,
   parameter int STATE_WIDTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   start,
   input  logic [D_WIDTH-1:0]     dividend,
   input  logic [D_WIDTH-1:0]     divisor,
   output logic [D_WIDTH-1:0]     quotient,
   output logic [D_WIDTH-1:0]     remainder,
   output logic                   busy,
   output logic                   done,
   output logic                   div_by_zero,
   output logic [STATE_WIDTH-1:0] p_STATE
);

   localparam int CNT_W = $clog2(D_WIDTH + 1);

   typedef enum logic [STATE_WIDTH-1:0] {
      IDLE = STATE_WIDTH'(0),
      LOAD = STATE_WIDTH'(1),
      ITER = STATE_WIDTH'(2),
      DONE = STATE_WIDTH'(3)
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [D_WIDTH-1:0]   q_reg;
   logic [D_WIDTH-1:0]   d_reg;
   logic [D_WIDTH:0]     r_reg;
   logic [CNT_W-1:0]     cnt;
   logic [D_WIDTH+1:0]   r_shift;
   logic [D_WIDTH+1:0]   trial;
   logic                 trial_neg;
   logic [D_WIDTH:0]     r_iter;
   logic [D_WIDTH-1:0]   q_iter;
   logic                 last_iter;

   // r_shift keeps the old R MSB so the extra sign bit of trial is exact
   always_comb begin
      r_shift   = {r_reg, q_reg[D_WIDTH-1]};
      trial     = r_shift - {2'b00, d_reg};
      trial_neg = trial[D_WIDTH+1];
      r_iter    = trial_neg ? r_shift[D_WIDTH:0] : trial[D_WIDTH:0];
      q_iter    = {q_reg[D_WIDTH-2:0], ~trial_neg};
      last_iter = (cnt == CNT_W'(D_WIDTH - 1));
   end

`ifdef DIV_BY_ZERO_DETECT_EN
   logic zero_div;
   logic dbz_reg;
   assign zero_div    = (divisor == '0);
   assign div_by_zero = dbz_reg;
`else
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef DIV_BY_ZERO_DETECT_EN
               state_next = zero_div ? DONE : LOAD;
`else
               state_next = LOAD;
`endif
            end
         end
         LOAD: begin
            busy       = 1'b1;
            state_next = ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Results are loaded on the last iteration edge so they are valid while done is high
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         q_reg     <= '0;
         d_reg     <= '0;
         r_reg     <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
         dbz_reg   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  q_reg <= dividend;
                  d_reg <= divisor;
                  r_reg <= '0;
                  cnt   <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
                  if (zero_div) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     dbz_reg   <= 1'b1;
                  end
`endif
               end
            end
            LOAD: cnt <= '0;
            ITER: begin
               r_reg <= r_iter;
               q_reg <= q_iter;
               cnt   <= cnt + CNT_W'(1);
               if (last_iter) begin
                  quotient  <= q_iter;
                  remainder <= r_iter[D_WIDTH-1:0];
`ifdef DIV_BY_ZERO_DETECT_EN
                  dbz_reg   <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign p_STATE = state;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed self-checking bench for shift_sub_divider (D_WIDTH=8).
// Zero-divisor expectations follow DIV_BY_ZERO_DETECT_EN when it is defined.
module tb_shift_sub_divider;

   localparam int W = 8;

   logic         i_clk;
   logic         i_rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [3:0]   p_STATE;

   int compared   = 0;
   int mismatched = 0;

   shift_sub_divider #(.D_WIDTH(W), .STATE_WIDTH(4)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .remainder(remainder),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero),
      .p_STATE(p_STATE)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Pulses start for one edge, then counts edges after the start edge until done
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit walk, output int edges);
      @(negedge i_clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge i_clk);
      #1;
      start = 1'b0;
      edges = 0;
      if (walk) checkOutput("walk_load", 32'(p_STATE), 32'd1);
      while (!done && edges < 40) begin
         @(posedge i_clk);
         #1;
         edges++;
         if (walk && !done) checkOutput("walk_iter", 32'(p_STATE), 32'd2);
      end
      if (walk) checkOutput("walk_done", 32'(p_STATE), 32'd3);
   endtask

   task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input int exp_lat, input logic exp_dbz, input bit walk);
      int edges;
      applyStimulus(a, b, walk, edges);
      checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_lat));
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_quot"}, 32'(quotient), 32'(exp_q));
      checkOutput({tag, "_rem"}, 32'(remainder), 32'(exp_r));
      checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
      @(posedge i_clk);
      #1;
      checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
      checkOutput({tag, "_idle"}, 32'(p_STATE), 32'd0);
      checkOutput({tag, "_quot_hold"}, 32'(quotient), 32'(exp_q));
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   vec_t vecs[8] = '{
      '{8'd255, 8'd1,   8'd255, 8'd0},
      '{8'd5,   8'd9,   8'd0,   8'd5},
      '{8'd0,   8'd3,   8'd0,   8'd0},
      '{8'd255, 8'd255, 8'd1,   8'd0},
      '{8'd128, 8'd16,  8'd8,   8'd0},
      '{8'd1,   8'd255, 8'd0,   8'd1},
      '{8'd200, 8'd13,  8'd15,  8'd5},
      '{8'd250, 8'd3,   8'd83,  8'd1}
   };

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int edges;
      int ndone;
      int first_done;
      int last_done;

      i_rst    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      checkOutput("rst_quot", 32'(quotient), 32'd0);
      checkOutput("rst_rem", 32'(remainder), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
      checkOutput("rst_state", 32'(p_STATE), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      $display("[TB] 200 / 7 with state walk");
      runOp("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 9, 1'b0, 1'b1);

      foreach (vecs[i]) begin
         runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 9, 1'b0, 1'b0);
      end

      $display("[TB] 100 / 0");
`ifdef DIV_BY_ZERO_DETECT_EN
      runOp("zero", 8'd100, 8'd0, 8'd255, 8'd100, 0, 1'b1, 1'b0);
`else
      runOp("zero", 8'd100, 8'd0, 8'd255, 8'd100, 9, 1'b0, 1'b0);
`endif

      // A second start mid-operation must neither be queued nor disturb results
      $display("[TB] start ignored during ITER");
      @(negedge i_clk);
      dividend = 8'd50;
      divisor  = 8'd6;
      start    = 1'b1;
      @(posedge i_clk);
      #1;
      start = 1'b0;
      edges = 0;
      repeat (3) begin
         @(posedge i_clk);
         #1;
         edges++;
      end
      @(negedge i_clk);
      dividend = 8'd9;
      divisor  = 8'd2;
      start    = 1'b1;
      @(posedge i_clk);
      #1;
      edges++;
      start = 1'b0;
      checkOutput("ign_state", 32'(p_STATE), 32'd2);
      checkOutput("ign_quot_mid", 32'(quotient), 32'd255);
      checkOutput("ign_rem_mid", 32'(remainder), 32'd100);
      while (!done && edges < 40) begin
         @(posedge i_clk);
         #1;
         edges++;
      end
      checkOutput("ign_latency", 32'(edges), 32'd9);
      checkOutput("ign_quot", 32'(quotient), 32'd8);
      checkOutput("ign_rem", 32'(remainder), 32'd2);
      repeat (2) begin
         @(posedge i_clk);
         #1;
      end
      checkOutput("ign_no_restart", 32'(p_STATE), 32'd0);

      $display("[TB] reset during ITER");
      @(negedge i_clk);
      dividend = 8'd77;
      divisor  = 8'd3;
      start    = 1'b1;
      @(posedge i_clk);
      #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge i_clk);
         #1;
      end
      checkOutput("rst_mid_pre", 32'(p_STATE), 32'd2);
      i_rst = 1'b1;
      #1;
      checkOutput("rst_mid_state", 32'(p_STATE), 32'd0);
      checkOutput("rst_mid_quot", 32'(quotient), 32'd0);
      checkOutput("rst_mid_rem", 32'(remainder), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      runOp("after_rst", 8'd12, 8'd5, 8'd2, 8'd2, 9, 1'b0, 1'b0);

      $display("[TB] start held high");
      ndone      = 0;
      first_done = -1;
      last_done  = -1;
      @(negedge i_clk);
      dividend = 8'd200;
      divisor  = 8'd7;
      start    = 1'b1;
      for (int e = 0; e < 40; e++) begin
         @(posedge i_clk);
         #1;
         if (e == 29) start = 1'b0;
         if (e == 10) checkOutput("held_idle_gap", 32'(p_STATE), 32'd0);
         if (e == 11) checkOutput("held_restart", 32'(p_STATE), 32'd1);
         if (done) begin
            ndone++;
            if (first_done < 0) first_done = e;
            else checkOutput("held_period", 32'(e - last_done), 32'd11);
            last_done = e;
         end
      end
      checkOutput("held_count", 32'(ndone), 32'd3);
      checkOutput("held_first", 32'(first_done), 32'd9);
      checkOutput("held_quot", 32'(quotient), 32'd28);
      checkOutput("held_rem", 32'(remainder), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
